load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store engine between the datapath's ALU result / rs2 read port and the data-memory bus. It converts a core memory request (address, store data, funct3) into a word-aligned bus transaction with byte enables. It also returns sign- or zero-extended load data and stalls the core until the access completes. Misaligned or illegal accesses and bus timeouts are reported as one-cycle faults.

## Interface
Parameters:
- D_WIDTH, 32, data and address width; only 32 is supported.
- TIMEOUT, 16, maximum cycles in BUS without `bus_ack` before a bus error; must be ≥ 2.

Ports (single clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- mem_req  in  1  current instruction is a load or store.
- MemWrite  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign code.
- addr  in  32  byte address, taken from ALU result.
- wdata  in  32  store data, taken from rs2.
- stall  out  1  hold PC and register writes.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load data; valid when `done`=1.
- fault_misalign  out  1  pulses with `done` on a misaligned or illegal access.
- fault_bus  out  1  pulses with `done` on a timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  word address; bits [1:0] are always 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  bus completion, sampled in BUS.
- bus_rdata  in  32  read word, valid when `bus_ack`=1.

## Operation
- States: IDLE, BUS, RESP.
- IDLE with `mem_req`=1 and a legal, aligned access:
  - Latch `MemWrite`, `funct3` and `addr[1:0]`.
  - Register the `bus_*` outputs.
  - Go to BUS.
- IDLE with `mem_req`=1 and an illegal or misaligned access:
  - Go to RESP with `fault_misalign` set; no bus access is made.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Alignment rules:
  - Halfword accesses require `addr[0]`=0.
  - Word accesses require `addr[1:0]`=00.
- Byte enables:
  - Byte: `bus_be` = 0001 shifted left by `addr[1:0]`.
  - Halfword: `bus_be` = 0011 if `addr[1]`=0, else 1100.
  - Word: `bus_be` = 1111.
  - Loads drive the same enables as stores.
- Store data: byte stores replicate `wdata[7:0]` four times; halfword stores replicate `wdata[15:0]` twice; word stores pass `wdata` unchanged.
- Load data: select the byte lane `addr[1:0]` or halfword lane `addr[1]` of `bus_rdata`. LB/LH sign-extend; LBU/LHU zero-extend. Capture the result into `rdata` on `bus_ack`.
- BUS:
  - Hold `bus_req`=1 and keep all `bus_*` outputs stable.
  - A cycle counter starts at 0 on entry.
  - On `bus_ack`=1, go to RESP.
  - If the counter reaches TIMEOUT-1 without `bus_ack`, go to RESP with `fault_bus` set and `rdata` unchanged.
  - If `bus_ack` arrives in the limit cycle, `bus_ack` takes priority and no fault is raised.
- RESP:
  - `done`=1, and the fault flag is set if one was recorded.
  - `mem_req` is ignored, because it is still the same instruction.
  - Always return to IDLE.
- `stall` = (IDLE and `mem_req`) or BUS. This is the only combinational output.
- `bus_ack` outside BUS is ignored.

## Timing
- Reset values:
  - State = IDLE, counter = 0.
  - `rdata`, all `bus_*` outputs, `done` and both fault flags = 0.
  - `stall` follows its formula, so it is 0 whenever `mem_req`=0.
- Reset mid-BUS: `bus_req` is 0 in the cycle after `rst` is sampled. The transaction is abandoned and no `done` pulse is produced.
- Cycle numbering: request sampled in cycle 0; BUS begins in cycle 1 with `bus_req`=1.
- Ack in cycle k (k ≥ 1): RESP in cycle k+1, with `done`=1 and `rdata` valid. Minimum load-to-use latency is 2 cycles after the request.
- Misaligned or illegal access: RESP in cycle 1, `bus_req` never asserts.
- Timeout: `bus_req` is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT), then RESP in cycle TIMEOUT+1.
- `stall` is 0 during RESP, so the core advances at the end of RESP. A new `mem_req` can be accepted in the cycle after RESP.
- `rdata` holds its last captured value between accesses.

## Test plan
- Reset: assert `rst` for 2 cycles with `mem_req`=1 → all outputs 0 except `stall`=1; after release, FSM accepts the request next cycle.
- LW `addr`=0x100, ack on the 3rd BUS cycle with `bus_rdata`=0xDEADBEEF → `bus_addr`=0x100, `bus_be`=1111, `bus_we`=0; `stall` high for 4 cycles; `done`=1 with `rdata`=0xDEADBEEF.
- Loads with `bus_rdata`=0x80FF0000 →
  - LB 0x103: `rdata`=0xFFFFFF80.
  - LBU 0x103: `rdata`=0x00000080.
  - LH 0x102: `rdata`=0xFFFF80FF.
  - LHU 0x100: `rdata`=0x00000000.
- Stores →
  - SB 0x201 with `wdata`=0x000000AB: `bus_be`=0010, `bus_wdata`=0xABABABAB, `bus_we`=1, `bus_addr`=0x200.
  - SH 0x202 with `wdata`=0x00001234: `bus_be`=1100, `bus_wdata`=0x12341234.
- Faults →
  - LW 0x102, SH 0x301 and funct3=011: no `bus_req`; `done` and `fault_misalign` both 1 in cycle 1.
- Timeout and reset → with TIMEOUT=16 and no ack: `bus_req` is high for 16 cycles, then `done`=1 and `fault_bus`=1. A repeat with `rst` asserted in BUS cycle 5 gives `bus_req`=0 the next cycle and no `done`.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: turns a core memory request into a word-aligned
// bus transaction with byte enables, returns extended load data and flags faults.
module load_store_unit #(
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req,
  input  logic               MemWrite,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] wdata,
  output logic               stall,
  output logic               done,
  output logic [D_WIDTH-1:0] rdata,
  output logic               fault_misalign,
  output logic               fault_bus,
  output logic               bus_req,
  output logic               bus_we,
  output logic [D_WIDTH-1:0] bus_addr,
  output logic [3:0]         bus_be,
  output logic [D_WIDTH-1:0] bus_wdata,
  input  logic               bus_ack,
  input  logic [D_WIDTH-1:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2:0]         lat_f3;
  logic [1:0]         lat_off;
  logic               legal;
  logic [3:0]         req_be;
  logic [D_WIDTH-1:0] req_wdata;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [D_WIDTH-1:0] ld_data;

  assign stall = ((state == IDLE) && mem_req) || (state == BUS);

  always_comb begin
    legal     = 1'b1;
    req_be    = 4'b1111;
    req_wdata = wdata;
    if (funct3[1:0] == 2'b11) legal = 1'b0;
    // Unsigned variants exist only for byte/halfword loads.
    if (funct3[2] && (MemWrite || (funct3[1:0] == 2'b10))) legal = 1'b0;
    if ((funct3[1:0] == 2'b01) && addr[0]) legal = 1'b0;
    if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) legal = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_be    = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = bus_rdata[{lat_off, 3'b000} +: 8];
    ld_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lat_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_f3         <= '0;
      lat_off        <= '0;
      rdata          <= '0;
      done           <= 1'b0;
      fault_misalign <= 1'b0;
      fault_bus      <= 1'b0;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_be         <= '0;
      bus_wdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            if (legal) begin
              lat_f3    <= funct3;
              lat_off   <= addr[1:0];
              bus_req   <= 1'b1;
              bus_we    <= MemWrite;
              bus_addr  <= {addr[D_WIDTH-1:2], 2'b00};
              bus_be    <= req_be;
              bus_wdata <= req_wdata;
              cnt       <= '0;
              state     <= BUS;
            end else begin
              done           <= 1'b1;
              fault_misalign <= 1'b1;
              state          <= RESP;
            end
          end
        end
        BUS: begin
          // Ack wins over timeout when both land in the limit cycle.
          if (bus_ack) begin
            if (!bus_we) rdata <= ld_data;
            bus_req <= 1'b0;
            done    <= 1'b1;
            state   <= RESP;
          end else if (cnt == CNT_LAST) begin
            bus_req   <= 1'b0;
            done      <= 1'b1;
            fault_bus <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          done           <= 1'b0;
          fault_misalign <= 1'b0;
          fault_bus      <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against an arithmetic model.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, mem_req, MemWrite, bus_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, bus_rdata;
  logic        stall, done, fault_misalign, fault_bus, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int unsigned ncmp = 0;
  int unsigned nfail = 0;
  logic [31:0] exp_rdata = '0;

  load_store_unit #(.D_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .MemWrite(MemWrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .fault_misalign(fault_misalign), .fault_bus(fault_bus),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: access size in bytes is 2**funct3[1:0].
  function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned s = int'(f3) % 4;
    if (s == 3) return 1'b0;
    if (f3 >= 4 && (we || s == 2)) return 1'b0;
    return (a % (32'd1 << s)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned nb = 1 << (int'(f3) % 4);
    int unsigned v = ((1 << nb) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (int'(f3) % 4)
      0:       return (wd & 32'hFF) * 32'h01010101;
      1:       return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rw);
    int unsigned nb = 1 << (int'(f3) % 4);
    logic [31:0] mask = (nb == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nb)) - 1);
    logic [31:0] v = (rw >> (8 * (a % 4))) & mask;
    if (f3 < 4 && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_cycle();
    mem_req = 1'b0;
    bus_ack = 1'($urandom);
    bus_rdata = $urandom;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_bus_req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;
  endtask

  // ackk = BUS cycle (1..TO) carrying bus_ack; 0 = never ack.
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rw, input int ackk);
    bit ok = m_legal(we, f3, a);
    bit timed_out = 1'b0;
    mem_req = 1'b1; MemWrite = we; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
    #1 chk("req_stall", 32'(stall), 32'd1);
    if (!ok) begin
      @(negedge clk);
      chk("mis_done", 32'(done), 32'd1);
      chk("mis_fault", 32'(fault_misalign), 32'd1);
      chk("mis_fault_bus", 32'(fault_bus), 32'd0);
      chk("mis_bus_req", 32'(bus_req), 32'd0);
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_rdata", rdata, exp_rdata);
      mem_req = 1'b0;
      return;
    end
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      chk("bus_req", 32'(bus_req), 32'd1);
      chk("bus_stall", 32'(stall), 32'd1);
      chk("bus_done", 32'(done), 32'd0);
      if (c == 1) begin
        chk("bus_addr", bus_addr, a & 32'hFFFFFFFC);
        chk("bus_be", 32'(bus_be), 32'(m_be(f3, a)));
        chk("bus_we", 32'(bus_we), 32'(we));
        if (we) chk("bus_wdata", bus_wdata, m_wdata(f3, wd));
      end
      if (c == ackk) begin
        bus_ack = 1'b1;
        bus_rdata = rw;
        break;
      end
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (c == TO) timed_out = 1'b1;
    end
    if (!timed_out && !we) exp_rdata = m_load(f3, a, rw);
    @(negedge clk);
    bus_ack = 1'b0;
    chk("resp_done", 32'(done), 32'd1);
    chk("resp_fault_bus", 32'(fault_bus), 32'(timed_out));
    chk("resp_fault_mis", 32'(fault_misalign), 32'd0);
    chk("resp_rdata", rdata, exp_rdata);
    chk("resp_bus_req", 32'(bus_req), 32'd0);
    chk("resp_stall", 32'(stall), 32'd0);
    mem_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_req = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
    addr = 32'h100; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_faults", 32'({fault_misalign, fault_bus}), 32'd0);
    rst = 1'b0;

    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    chk("lw_const", rdata, 32'hDEADBEEF);
    idle_cycle();
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1);
    chk("lb_const", rdata, 32'hFFFFFF80);
    idle_cycle();
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 2);
    chk("lbu_const", rdata, 32'h00000080);
    idle_cycle();
    access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 1);
    chk("lh_const", rdata, 32'hFFFF80FF);
    idle_cycle();
    access(1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF0000, 1);
    chk("lhu_const", rdata, 32'h00000000);
    idle_cycle();
    access(1'b1, 3'b000, 32'h201, 32'hAB, 32'h0, 2);
    idle_cycle();
    access(1'b1, 3'b001, 32'h202, 32'h1234, 32'h0, 1);
    idle_cycle();
    access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1);
    idle_cycle();
    access(1'b1, 3'b001, 32'h301, 32'h0, 32'h0, 1);
    idle_cycle();
    access(1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 1);
    idle_cycle();
    access(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 0);
    idle_cycle();
    access(1'b0, 3'b010, 32'h504, 32'h0, 32'h13579BDF, TO);
    idle_cycle();

    // Reset while in BUS: transaction abandoned, no done pulse.
    mem_req = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h400;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("rbus_req", 32'(bus_req), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rbus_req_after", 32'(bus_req), 32'd0);
    chk("rbus_done", 32'(done), 32'd0);
    rst = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    chk("rbus_done2", 32'(done), 32'd0);
    exp_rdata = '0;
    chk("rbus_rdata", rdata, exp_rdata);
    back_to_back_and_random();
  end

  task automatic back_to_back_and_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      idle_cycle();
      access(1'($urandom), 3'($urandom), a, $urandom, $urandom,
             ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4)));
    end
    idle_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  endtask

endmodule
